// File: rtl/ht_cmd_arb_pkg.sv
// ============================================================================
// hash_table : shared hash-table command types and arbiter limits
// Rev 1.0
// ============================================================================
`default_nettype none

package hash_table;

    localparam int HT_ARB_REQ_CNT_MAX = 8;

    typedef enum logic [2:0] {
        OP_INIT   = 3'd0,
        OP_SEARCH = 3'd1,
        OP_INSERT = 3'd2,
        OP_DELETE = 3'd3,
        OP_UPDATE = 3'd4
    } ht_opcode_t;

    typedef struct packed {
        ht_opcode_t  opcode;
        logic [4:0]  tbl_id;
    } ht_cmd_t;

    typedef struct packed {
        ht_cmd_t     cmd;
        logic [31:0] key;
        logic [31:0] value;
    } ht_pdata_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ht_arb_stage_t;

endpackage

`default_nettype wire

// File: rtl/ht_cmd_arb_if.sv
// ============================================================================
// ht_cmd_arb_if : requester-side and demux-side command bus of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface ht_cmd_arb_if
    import hash_table::*;
#(
    parameter int REQ_CNT = 4,
    parameter int ID_W    = $clog2(REQ_CNT)
);
    ht_pdata_t          req_pdata_i [REQ_CNT];
    logic [REQ_CNT-1:0] req_valid_i;
    logic [REQ_CNT-1:0] req_ready_o;
    ht_pdata_t          pdata_o;
    logic               pdata_valid_o;
    logic               pdata_ready_i;
    logic [ID_W-1:0]    grant_id_o;

    modport slave (
        input  req_pdata_i, req_valid_i, pdata_ready_i,
        output req_ready_o, pdata_o, pdata_valid_o, grant_id_o
    );

    modport master (
        output req_pdata_i, req_valid_i, pdata_ready_i,
        input  req_ready_o, pdata_o, pdata_valid_o, grant_id_o
    );
endinterface

`default_nettype wire

// File: rtl/ht_rr_pick.sv
// ============================================================================
// ht_rr_pick : combinational first-set search over a mask, starting at a pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module ht_rr_pick #(
    parameter int REQ_CNT = 4,
    parameter int ID_W    = $clog2(REQ_CNT)
) (
    input  wire logic [REQ_CNT-1:0] i_mask,
    input  wire logic [ID_W-1:0]    i_ptr,
    output logic      [ID_W-1:0]    o_grant,
    output logic                    o_found
);
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        o_grant = '0;
        o_found = |i_mask;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = REQ_CNT - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(REQ_CNT)) begin
                w_sum = w_sum - (ID_W+1)'(REQ_CNT);
            end
            w_idx = w_sum[ID_W-1:0];
            if (i_mask[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/ht_cmd_arb.sv
// ============================================================================
// ht_cmd_arb : round-robin command arbiter with one-entry registered output;
//              opcode affinity enabled by HT_ARB_OPCODE_AFFINITY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ht_cmd_arb
    import hash_table::*;
#(
    parameter int REQ_CNT = 4,
    parameter int AFF_MAX = 8,
    parameter int ID_W    = $clog2(REQ_CNT)
) (
    input wire logic     clk_i,
    input wire logic     rst_i,
    ht_cmd_arb_if.slave  bus
);
    if (REQ_CNT < 2 || REQ_CNT > HT_ARB_REQ_CNT_MAX || AFF_MAX < 1) begin : g_bad_cfg
        $error("ht_cmd_arb: unsupported REQ_CNT/AFF_MAX");
    end

    ht_arb_stage_t      r_state;
    ht_arb_stage_t      w_state_nxt;
    ht_pdata_t          r_pdata;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [REQ_CNT-1:0] w_mask;
    logic               w_found;
    logic               w_load_en;
    logic               w_xfer;

    assign w_load_en = (r_state == ST_EMPTY) || bus.pdata_ready_i;
    assign w_xfer    = w_load_en && w_found;
    assign w_ptr_nxt = (w_grant == ID_W'(REQ_CNT - 1)) ? '0 : w_grant + 1'b1;

`ifdef HT_ARB_OPCODE_AFFINITY_EN
    localparam int AFF_W = $clog2(AFF_MAX + 1);

    ht_opcode_t         r_last_op;
    logic [AFF_W-1:0]   r_aff_cnt;
    logic [REQ_CNT-1:0] w_aff_mask;
    logic               w_use_aff;

    always_comb begin
        w_aff_mask = '0;
        for (int g = 0; g < REQ_CNT; g++) begin
            w_aff_mask[g] = bus.req_valid_i[g] && (bus.req_pdata_i[g].cmd.opcode == r_last_op);
        end
    end

    // Affinity run is capped so a lone different opcode cannot starve.
    assign w_use_aff = (|w_aff_mask) && (r_aff_cnt < AFF_W'(AFF_MAX));
    assign w_mask    = w_use_aff ? w_aff_mask : bus.req_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_op <= OP_INIT;
            r_aff_cnt <= '0;
        end else if (w_xfer) begin
            r_last_op <= bus.req_pdata_i[w_grant].cmd.opcode;
            r_aff_cnt <= w_use_aff ? r_aff_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_mask = bus.req_valid_i;
`endif

    ht_rr_pick #(
        .REQ_CNT (REQ_CNT),
        .ID_W    (ID_W)
    ) u_pick (
        .i_mask  (w_mask),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    always_comb begin
        bus.req_ready_o = '0;
        if (!rst_i && w_xfer) begin
            bus.req_ready_o[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A same-cycle unload and load keeps the stage full with the new command.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if (bus.pdata_ready_i) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pdata    <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else if (w_xfer) begin
            r_pdata    <= bus.req_pdata_i[w_grant];
            r_grant_id <= w_grant;
            r_rr_ptr   <= w_ptr_nxt;
        end
    end

    assign bus.pdata_o       = r_pdata;
    assign bus.pdata_valid_o = (r_state == ST_FULL);
    assign bus.grant_id_o    = r_grant_id;
endmodule

`default_nettype wire

// File: tb/tb_ht_cmd_arb.sv
// ============================================================================
// tb_ht_cmd_arb : randomized scoreboard bench for ht_cmd_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ht_cmd_arb;
    import hash_table::*;

    localparam int N   = 4;
    localparam int AFF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ht_cmd_arb_if #(.REQ_CNT(N)) bus ();

    ht_cmd_arb #(
        .REQ_CNT (N),
        .AFF_MAX (AFF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        ht_pdata_t d;
        int        id;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         m_full;
    int         m_ptr;
    ht_opcode_t m_last;
    int         m_aff;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ht_pdata_t rnd_pd(input int i, input bit fixed);
        ht_pdata_t p;
        p.key        = $urandom;
        p.value      = $urandom;
        p.cmd.tbl_id = 5'($urandom);
        if (fixed) p.cmd.opcode = (i % 2 == 0) ? OP_SEARCH : OP_INSERT;
        else       p.cmd.opcode = ($urandom_range(0, 1) == 0) ? OP_SEARCH : OP_INSERT;
        return p;
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_full = 0;
        m_ptr  = 0;
        m_last = OP_INIT;
        m_aff  = 0;
    endtask

    // One clock: apply stimulus, predict the grant, queue the expected output.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input bit fixed);
        ht_pdata_t  pd [N];
        logic [N-1:0] cand;
        logic [N-1:0] same;
        logic [N-1:0] exp_rdy;
        bit         load;
        bit         aff;
        int         g;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            pd[i] = rnd_pd(i, fixed);
            bus.req_pdata_i[i] = pd[i];
        end
        bus.req_valid_i   = v;
        bus.pdata_ready_i = rdy;
        #1;
        chk("pdata_valid", bus.pdata_valid_o, m_full);
        load = (m_full == 0) || rdy;
        cand = v;
        aff  = 1'b0;
        same = '0;
`ifdef HT_ARB_OPCODE_AFFINITY_EN
        for (int i = 0; i < N; i++) same[i] = v[i] && (pd[i].cmd.opcode == m_last);
        aff = (same != '0) && (m_aff < AFF);
        if (aff) cand = same;
`endif
        g = load ? pick(cand, m_ptr) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", bus.req_ready_o, exp_rdy);
        if (g >= 0) begin
            q.push_back('{d: pd[g], id: g});
            m_ptr  = (g + 1) % N;
            m_full = 1;
            m_aff  = aff ? m_aff + 1 : 0;
            m_last = pd[g].cmd.opcode;
        end else if (rdy) begin
            m_full = 0;
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pdata_valid", bus.pdata_valid_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 0);
        model_reset();
        @(posedge clk);
        #2;
        bus.req_valid_i = '0;
        rst = 1'b0;
    endtask

    // Monitor: every output handshake consumes one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.pdata_valid_o && bus.pdata_ready_i) begin
                chk("scoreboard_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("pdata", bus.pdata_o, e.d);
                    chk("grant_id", bus.grant_id_o, e.id);
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) bus.req_pdata_i[i] = rnd_pd(i, 1'b0);
        bus.req_valid_i   = '1;
        bus.pdata_ready_i = 1'b1;
        rst = 1'b1;
        #12;
        chk("reset_valid", bus.pdata_valid_o, 0);
        chk("reset_pdata", bus.pdata_o, 0);
        chk("reset_grant_id", bus.grant_id_o, 0);
        chk("reset_req_ready", bus.req_ready_o, 0);
        @(posedge clk);
        #2;
        bus.req_valid_i = '0;
        rst = 1'b0;

        // Single requester, back-to-back.
        repeat (5) cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // Fairness with everyone requesting.
        repeat (8) cycle(4'b1111, 1'b1, 1'b0);

        // Backpressure then release with no bubble.
        repeat (3) cycle(4'b1111, 1'b0, 1'b0);
        repeat (2) cycle(4'b1111, 1'b1, 1'b0);

        // Wrap between requesters 3 and 0.
        mid_reset();
        cycle(4'b0100, 1'b1, 1'b1);
        repeat (4) cycle(4'b1001, 1'b1, 1'b1);

`ifdef HT_ARB_OPCODE_AFFINITY_EN
        mid_reset();
        cycle(4'b0001, 1'b1, 1'b1);
        repeat (6) cycle(4'b0011, 1'b1, 1'b1);
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0));
        end

        // Reset while stalled full, then first grant goes to requester 0.
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0);
        mid_reset();
        cycle(4'b1111, 1'b1, 1'b0);

        repeat (3) cycle(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ht_cmd_arb.md
Name: ht_cmd_arb

Overview:
- Round-robin arbiter sharing the single hash-table command input (the task demultiplexer's pdata stream) between REQ_CNT independent command sources, e.g. host ports or a management engine.
- Registers the winning command in a one-entry output stage.
- Tags the command with the winner's index.
- Optionally prefers requesters whose opcode matches the last granted opcode, which reduces demux stalls on opcode switches.

Parameters:
- REQ_CNT, 4, number of requesters (2..8).
- AFF_MAX, 8, max consecutive affinity-driven grants before one forced plain round-robin grant (affinity build only).
- ID_W, $clog2(REQ_CNT), width of the grant tag.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_pdata_i  in  ht_pdata_t [REQ_CNT]  per-requester command
- req_valid_i  in  1 [REQ_CNT]  per-requester valid
- req_ready_o  out  1 [REQ_CNT]  per-requester ready; only the granted requester sees 1
- pdata_o  out  ht_pdata_t  registered winning command, to demux pdata_in_i
- pdata_valid_o  out  1  output stage full
- pdata_ready_i  in  1  demux pdata_in_ready_o
- grant_id_o  out  ID_W  index of requester that supplied pdata_o

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous, active-high.
- Reset values: pdata_valid_o=0, pdata_o=0, grant_id_o=0, rr_ptr=0, last_op=OP_INIT, aff_cnt=0.
- req_ready_o is combinational and is 0 for all requesters while rst_i is high.
- Output stage states:
  - EMPTY (pdata_valid_o=0).
  - FULL (pdata_valid_o=1).
- Load condition: load_en = !pdata_valid_o || pdata_ready_i.
- Arbitration runs only when load_en=1 and at least one req_valid_i is set.
  - Exactly one grant per cycle; req_ready_o[g]=load_en && (g==grant).
  - Transfer from requester g occurs when req_valid_i[g] && req_ready_o[g].
  - On transfer: pdata_o<=req_pdata_i[g], grant_id_o<=g, pdata_valid_o<=1.
- Unload: if pdata_ready_i=1 while FULL and no new transfer occurs, pdata_valid_o<=0.
- Simultaneous unload and load in the same cycle: the output stays FULL with the new data. Throughput is 1 command/cycle with zero bubbles.
- Stall: while FULL and pdata_ready_i=0, pdata_o and grant_id_o are held stable and every req_ready_o=0.
- Plain round-robin: the winner is the first valid requester at or after rr_ptr, wrapping modulo REQ_CNT. After a grant g, rr_ptr<=(g+1) mod REQ_CNT (wraps at REQ_CNT-1 -> 0).
- A requester dropping valid without a handshake is allowed; the grant is recomputed every cycle and no grant is held.
- Latency: a command accepted in cycle N is presented on pdata_o in cycle N+1.
- Reset mid-operation: a command held in the output stage is discarded and the arbiter restarts at requester 0.
- pdata content is passed through untouched. The opcode is read only for affinity.

Optional Feature:
- Macro: HT_ARB_OPCODE_AFFINITY_EN.
- When defined, the candidate mask is the valid requesters whose req_pdata_i.cmd.opcode==last_op.
  - If this mask is non-empty and aff_cnt<AFF_MAX, the round-robin search runs over the mask only, and aff_cnt increments on grant.
  - Otherwise the search runs over all valid requesters and aff_cnt<=0.
  - last_op<=opcode of every granted command.
  - rr_ptr updates identically in both paths.
- When undefined: last_op and aff_cnt do not exist; pure round-robin.

Decomposition:
- Package hash_table holds:
  - ht_pdata_t and the opcode enum (existing).
  - New constant HT_ARB_REQ_CNT_MAX=8.
- One sub-module, ht_rr_pick:
  - Combinational masked round-robin find-first; inputs mask[REQ_CNT], ptr; outputs grant index and found flag.
  - Instantiated once, with mask selected by affinity logic.

Test Plan:
- Single requester: req 2 valid with 5 back-to-back commands, pdata_ready_i=1 -> 5 outputs on consecutive cycles, grant_id_o=2, first output one cycle after first accept.
- Fairness: all 4 requesters continuously valid, ready=1, plain build -> grant_id_o sequence 0,1,2,3,0,1 ...
- Backpressure: ready=0 for 3 cycles while FULL -> pdata_o and grant_id_o stable, all req_ready_o=0. When ready returns to 1, a new grant is taken in the same cycle with no bubble.
- Wrap: only req 3 and req 0 valid, rr_ptr=3 -> grants 3,0,3,0.
- Affinity (macro on, AFF_MAX=2):
  - Setup: req0 issues SEARCH continuously, req1 issues INSERT continuously, last_op=SEARCH.
  - Expected -> grants 0,0,1 (forced RR), 1,1,0.
- Reset mid-stall: rst_i asserted while FULL -> pdata_valid_o=0 immediately (async), after release first grant goes to requester 0.
